// File: rtl/hex_display_sched.sv
// Round-robin time-sharing of the six seven-segment displays between requesters.
// Selected source is decoded nibble-wise into registered active-low segment outputs.
module hex_display_sched #(
  parameter int unsigned N_SRC = 3,
  parameter int unsigned DWELL = 25_000_000,
  parameter int unsigned CNT_W = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SRC-1:0]     src_valid,
  input  logic [24*N_SRC-1:0]  src_data,
  input  logic                 hold,
  output logic [6:0]           HEX0,
  output logic [6:0]           HEX1,
  output logic [6:0]           HEX2,
  output logic [6:0]           HEX3,
  output logic [6:0]           HEX4,
  output logic [6:0]           HEX5,
  output logic [1:0]           sel,
  output logic                 sel_valid
);

  localparam int unsigned MAX_SRC = 4;
  localparam int unsigned DATA_W  = 24;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [6:0]        hex_q [6];

  logic [MAX_SRC-1:0]        vld_c;
  logic [MAX_SRC*DATA_W-1:0] data_all_c;
  logic [DATA_W-1:0]         data_arr_c [MAX_SRC];
  logic [DATA_W-1:0]         cur_c;
  logic [1:0]                nxt_c;
  logic                      found_c;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // Pad sources to four slots so a 2-bit index never runs off the end.
  always_comb begin
    vld_c      = MAX_SRC'(src_valid);
    data_all_c = (MAX_SRC*DATA_W)'(src_data);
    for (int i = 0; i < int'(MAX_SRC); i++) begin
      data_arr_c[i] = data_all_c[DATA_W*i +: DATA_W];
    end
    cur_c = data_arr_c[sel];
  end

  // First valid index starting at sel+1, wrapping, with sel itself considered last.
  always_comb begin
    int idx;
    idx     = 0;
    nxt_c   = sel;
    found_c = 1'b0;
    for (int k = int'(N_SRC); k >= 1; k--) begin
      idx = (int'(sel) + k) % int'(N_SRC);
      if (vld_c[2'(idx)]) begin
        nxt_c   = 2'(idx);
        found_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= 2'd0;
      sel_valid <= 1'b0;
      cnt       <= '0;
      for (int k = 0; k < 6; k++) hex_q[k] <= 7'h7F;
    end else begin
      for (int k = 0; k < 6; k++) begin
        hex_q[k] <= sel_valid ? seg7(cur_c[4*k +: 4]) : 7'h7F;
      end
      case (state)
        IDLE: begin
          if (found_c) begin
            sel       <= nxt_c;
            cnt       <= '0;
            state     <= SHOW;
            sel_valid <= 1'b1;
          end
        end
        SHOW: begin
          if (!vld_c[sel]) begin
            cnt <= '0;
            if (found_c) begin
              sel <= nxt_c;
            end else begin
              state     <= IDLE;
              sel_valid <= 1'b0;
            end
          end else if (!hold && cnt == CNT_W'(DWELL - 1)) begin
            sel <= nxt_c;
            cnt <= '0;
          end else if (!hold) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          sel_valid <= 1'b0;
        end
      endcase
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_hex_display_sched.sv
// Scoreboard bench for hex_display_sched: a time-based reference model predicts
// sel, sel_valid and all six displays after every clock edge.
module tb_hex_display_sched;

  localparam int unsigned N     = 3;
  localparam int unsigned DWELL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    src_valid = 3'b000;
  logic [71:0]   src_data = '0;
  logic          hold = 1'b0;
  logic [6:0]    HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [1:0]    sel;
  logic          sel_valid;

  hex_display_sched #(.N_SRC(N), .DWELL(DWELL), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
    .hold(hold), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5), .sel(sel), .sel_valid(sel_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic        sv;
    logic [41:0] hex;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: "shown" flag, current source, cycles spent on it so far.
  bit m_active = 0;
  int m_sel    = 0;
  int m_age    = 0;

  function automatic int next_src(input int cur, input logic [2:0] v);
    for (int k = 1; k <= int'(N); k++) begin
      if (v[(cur + k) % int'(N)]) return (cur + k) % int'(N);
    end
    return -1;
  endfunction

  task automatic model_step();
    exp_t        e;
    logic [23:0] d;
    int          n;
    d = src_data[24*m_sel +: 24];
    for (int k = 0; k < 6; k++) begin
      e.hex[7*k +: 7] = (!reset && m_active) ? seg_tab[d[4*k +: 4]] : 7'h7F;
    end
    n = next_src(m_sel, src_valid);
    if (reset) begin
      m_active = 0; m_sel = 0; m_age = 0;
    end else if (!m_active) begin
      if (n >= 0) begin m_active = 1; m_sel = n; m_age = 0; end
    end else if (!src_valid[m_sel]) begin
      m_age = 0;
      if (n >= 0) m_sel = n;
      else m_active = 0;
    end else if (!hold) begin
      m_age++;
      if (m_age == int'(DWELL)) begin m_sel = n; m_age = 0; end
    end
    e.sel = 2'(m_sel);
    e.sv  = m_active;
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic [2:0] v, input logic [71:0] d, input logic h);
    @(negedge clk);
    reset = r; src_valid = v; src_data = d; hold = h;
    model_step();
  endtask

  // Monitor: compare the post-edge DUT outputs against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (sel_valid !== e.sv) begin
          miscompares++;
          $display("FAIL sel_valid t=%0t got %b want %b", $time, sel_valid, e.sv);
        end
        vectors++;
        if (sel !== e.sel) begin
          miscompares++;
          $display("FAIL sel t=%0t got %0d want %0d", $time, sel, e.sel);
        end
        vectors++;
        if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== e.hex) begin
          miscompares++;
          $display("FAIL hex t=%0t got %h want %h", $time,
                   {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, e.hex);
        end
      end
    end
  end

  initial begin
    logic [71:0] d;
    logic [2:0]  v;
    logic        h;
    d = {24'h000000, 24'hABCDEF, 24'h012345};

    // Idle after reset with nothing requesting.
    repeat (2) step(1'b1, 3'b000, d, 1'b0);
    repeat (20) step(1'b0, 3'b000, d, 1'b0);

    // Two sources alternating; hold stretches one dwell.
    repeat (14) step(1'b0, 3'b011, d, 1'b0);
    repeat (10) step(1'b0, 3'b011, d, 1'b1);
    repeat (10) step(1'b0, 3'b011, d, 1'b0);

    // Drop sources mid-dwell, including while held.
    repeat (2) step(1'b0, 3'b010, d, 1'b0);
    repeat (3) step(1'b0, 3'b011, d, 1'b0);
    repeat (2) step(1'b0, 3'b001, d, 1'b1);
    repeat (3) step(1'b0, 3'b000, d, 1'b0);

    // Single valid source stays selected across expiries.
    d = {24'h888888, 24'hABCDEF, 24'h012345};
    repeat (14) step(1'b0, 3'b100, d, 1'b0);

    // Reset at every phase of a dwell, including its expiry.
    for (int off = 0; off < 7; off++) begin
      step(1'b1, 3'b011, d, 1'b0);
      repeat (off + 1) step(1'b0, 3'b011, d, 1'b0);
      step(1'b1, 3'b011, d, 1'b1);
      step(1'b0, 3'b000, d, 1'b0);
    end

    // Randomized traffic.
    v = 3'b111;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) v = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) d = {$urandom(), $urandom(), 8'($urandom())};
      h = ($urandom_range(0, 4) == 0);
      step(($urandom_range(0, 99) == 0), v, d, h);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hex_display_sched.md
# hex_display_sched

Time-shares the six DE1-SoC seven-segment displays (HEX0–HEX5) between several requesters, such as the generation counter, the live-cell count and the status word. Each requester presents a 24-bit value (six hex nibbles) and a valid flag. The scheduler rotates round-robin among the valid requesters on a fixed dwell period. It decodes the selected value nibble-by-nibble and drives registered, active-low segment outputs that connect directly to the board pins, so no separate inversion stage is needed.

## Interface
- N_SRC, 3: number of requesters; legal range 2–4.
- DWELL, 25_000_000: cycles each source is shown (0.5 s at 50 MHz); must be ≥ 2.
- CNT_W, 25: dwell counter width; must satisfy 2^CNT_W ≥ DWELL.
- clk  in  1  system clock; everything is on its rising edge.
- reset  in  1  synchronous, active-high.
- src_valid  in  N_SRC  bit i high means source i is requesting display.
- src_data  in  24*N_SRC  source i occupies bits [24i+23:24i]; nibble k (bits [4k+3:4k]) drives HEXk.
- hold  in  1  freezes the dwell counter (pauses rotation).
- HEX0..HEX5  out  7 each  active-low segments; bit0 = a … bit6 = g.
- sel  out  2  index of the source currently shown.
- sel_valid  out  1  high while in SHOW.

## Operation
- FSM has two states, IDLE and SHOW.
- IDLE behaviour:
  - sel_valid = 0; the HEX outputs blank (7'h7F).
  - When any src_valid bit is high, load sel with the first valid index in round-robin order starting at sel+1 (mod N_SRC), clear the counter and go to SHOW.
- SHOW, each cycle, in priority order:
  1. If src_valid[sel] = 0: advance immediately to the next valid source in round-robin order starting at sel+1. If there is none, go to IDLE (sel keeps its value).
  2. Else if counter == DWELL-1 and hold = 0: advance to the next valid source starting at sel+1. If sel is the only valid source, stay on it. In both cases clear the counter.
  3. Else if hold = 0: counter += 1.
  4. hold = 1: counter keeps its value.
- Rule 1 (valid dropping) takes effect even while hold = 1.
- Every advance clears the counter.
- Round-robin search wraps from N_SRC-1 to 0 and considers the current index last.
- Display data is sampled live every cycle, so value changes on the shown source appear without waiting for a rotation.
- Decode table (standard hex, active-low):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (hex values of the 7-bit output)
- Source indices ≥ N_SRC are never selected.

## Timing
- Reset values: state = IDLE, sel = 0, sel_valid = 0, counter = 0, all HEX = 7'h7F.
- FSM and sel update at edge t.
- The HEX outputs register {sel_valid, decode(src_data[sel])} and show the new source at edge t+1, one cycle after sel changes.
- src_data changes at edge t are visible on HEX at edge t+1.
- Dwell with hold low: a source is shown for exactly DWELL cycles between advances.
- Dwell with hold high: the period stretches by the number of held cycles.
- All valid sources dropping at once while in SHOW: go to IDLE at the next edge; HEX blanks one edge later.
- Reset asserted mid-dwell: all reset values at the next edge, regardless of hold or valid.

## Test plan
Bench uses DWELL = 4 unless stated.
- Reset with src_valid = 3'b000: HEX0–5 = 7F, sel_valid = 0; remain so for 20 cycles.
- src_valid = 3'b011, src0 = 24'h012345, src1 = 24'hABCDEF from reset:
  - SHOW with sel = 1 first (search starts at sel+1 = 1).
  - HEX0 = 0E (F) … HEX5 = 08 (A).
  - sel alternates 1, 0, 1 every 4 cycles.
- sel = 0 shown and src_valid[0] falls mid-dwell: sel = 1 at the next edge, counter = 0; HEX updates one edge later.
- hold = 1 for 10 cycles during SHOW: sel unchanged for 4 + 10 cycles, then rotation resumes.
- Only src2 valid, src2 = 24'h888888: sel stays 2 across expiries; all HEX = 00.
- Reset asserted on the same cycle as a dwell expiry: next-edge sel = 0, state = IDLE, HEX = 7F.
